// File: rtl/m_call_ctrl.sv
// Call/return sequencer placed between the decoder/PC unit and the hardware
// stack. CALL, RET and interrupt-entry requests become single-cycle push or pop
// pulses. The controller keeps a local depth count and raises sticky
// overflow/underflow faults. Every output comes from a register.
//
// Request/ack handshake: call_req, ret_req and irq_req are levels. The requester
// holds a request high until it sees the one-cycle ack pulse, then drops it.
// The controller samples requests only in IDLE with no fault pending. Requests
// are ignored while busy=1 or fault=1. On a fault, ack is pulsed and no stack
// operation occurs.
module m_call_ctrl #(
    parameter int WORD    = 16,
    parameter int DEPTH   = 4,
    parameter int STK_LAT = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     call_req,
    input  logic                     ret_req,
    input  logic                     irq_req,
    input  logic [WORD-1:0]          pc,
    input  logic [WORD-1:0]          target,
    output logic                     busy,
    output logic                     ack,
    output logic                     pc_load,
    output logic [WORD-1:0]          pc_next,
    output logic                     irq_ret,
    output logic                     stk_push,
    output logic                     stk_pop,
    output logic [WORD:0]            stk_wdata,
    input  logic [WORD:0]            stk_rdata,
    input  logic                     stk_full,
    input  logic                     stk_empty,
    output logic [$clog2(DEPTH):0]   depth,
    output logic                     fault,
    output logic [1:0]               fault_code,
    input  logic                     fault_clr,
    output logic [2:0]               dbg_state
);

    localparam int DW = $clog2(DEPTH) + 1;
    localparam logic [DW-1:0]   DEPTH_MAX = DW'(DEPTH);
    localparam logic [DW-1:0]   DEPTH_ONE = DW'(1);
    localparam logic [WORD-1:0] PC_ONE    = WORD'(1);
    localparam logic [1:0]      LAT_INIT  = 2'(STK_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PUSH = 3'd1,
        S_POP  = 3'd2,
        S_WAIT = 3'd3,
        S_LOAD = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [WORD-1:0]   tgt_q, tgt_d;

    logic              busy_d, ack_d, pc_load_d, irq_ret_d, stk_push_d, stk_pop_d;
    logic [WORD-1:0]   pc_next_d;
    logic [WORD:0]     stk_wdata_d;
    logic [DW-1:0]     depth_d;
    logic              fault_d;
    logic [1:0]        fault_code_d;

    assign dbg_state = state_q;

    // Next-state and next-output logic; pulses default low every cycle.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        tgt_d        = tgt_q;
        ack_d        = 1'b0;
        pc_load_d    = 1'b0;
        irq_ret_d    = 1'b0;
        stk_push_d   = 1'b0;
        stk_pop_d    = 1'b0;
        pc_next_d    = pc_next;
        stk_wdata_d  = stk_wdata;
        depth_d      = depth;
        fault_d      = fault;
        fault_code_d = fault_code;

        case (state_q)
            S_IDLE: begin
                if (fault_clr) begin
                    fault_d      = 1'b0;
                    fault_code_d = 2'b00;
                end
                // Arbitration is only live with no fault pending; a fault
                // detected here overrides a simultaneous clear.
                if (!fault) begin
                    if (irq_req || call_req) begin
                        if (stk_full || depth == DEPTH_MAX) begin
                            fault_d      = 1'b1;
                            fault_code_d = 2'b01;
                            ack_d        = 1'b1;
                        end else begin
                            stk_push_d  = 1'b1;
                            stk_wdata_d = {irq_req, pc + PC_ONE};
                            tgt_d       = target;
                            state_d     = S_PUSH;
                        end
                    end else if (ret_req) begin
                        if (stk_empty || depth == '0) begin
                            fault_d      = 1'b1;
                            fault_code_d = 2'b10;
                            ack_d        = 1'b1;
                        end else begin
                            stk_pop_d = 1'b1;
                            cnt_d     = LAT_INIT;
                            state_d   = S_POP;
                        end
                    end
                end
            end
            S_PUSH: begin
                pc_load_d = 1'b1;
                ack_d     = 1'b1;
                pc_next_d = tgt_q;
                if (depth != DEPTH_MAX) depth_d = depth + DEPTH_ONE;
                state_d   = S_LOAD;
            end
            S_POP, S_WAIT: begin
                // Leave once the stack read latency has elapsed, capturing
                // the popped word on the way into LOAD.
                if (cnt_q == 2'd0) begin
                    pc_load_d = 1'b1;
                    ack_d     = 1'b1;
                    pc_next_d = stk_rdata[WORD-1:0];
                    irq_ret_d = stk_rdata[WORD];
                    if (depth != '0) depth_d = depth - DEPTH_ONE;
                    state_d   = S_LOAD;
                end else begin
                    cnt_d   = cnt_q - 2'd1;
                    state_d = S_WAIT;
                end
            end
            S_LOAD: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs; async reset abandons any in-flight operation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 2'd0;
            tgt_q      <= '0;
            busy       <= 1'b0;
            ack        <= 1'b0;
            pc_load    <= 1'b0;
            pc_next    <= '0;
            irq_ret    <= 1'b0;
            stk_push   <= 1'b0;
            stk_pop    <= 1'b0;
            stk_wdata  <= '0;
            depth      <= '0;
            fault      <= 1'b0;
            fault_code <= 2'b00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tgt_q      <= tgt_d;
            busy       <= busy_d;
            ack        <= ack_d;
            pc_load    <= pc_load_d;
            pc_next    <= pc_next_d;
            irq_ret    <= irq_ret_d;
            stk_push   <= stk_push_d;
            stk_pop    <= stk_pop_d;
            stk_wdata  <= stk_wdata_d;
            depth      <= depth_d;
            fault      <= fault_d;
            fault_code <= fault_code_d;
        end
    end

endmodule

// File: tb/tb_m_call_ctrl.sv
// Bench for m_call_ctrl: a small stack device model, a scoreboard of expected
// push words and PC redirects, and one task per scenario.
module tb_m_call_ctrl;

    localparam int WORD    = 16;
    localparam int DEPTH   = 4;
    localparam int STK_LAT = 2;

    logic              clk;
    logic              reset;
    logic              call_req, ret_req, irq_req;
    logic [WORD-1:0]   pc, target;
    logic              busy, ack, pc_load, irq_ret, stk_push, stk_pop;
    logic [WORD-1:0]   pc_next;
    logic [WORD:0]     stk_wdata, stk_rdata;
    logic              stk_full, stk_empty;
    logic [2:0]        depth;
    logic              fault;
    logic [1:0]        fault_code;
    logic              fault_clr;
    logic [2:0]        dbg_state;

    int checks   = 0;
    int failures = 0;
    int push_cnt = 0;
    int pop_cnt  = 0;
    int load_cnt = 0;
    int exp_depth = 0;

    logic [WORD:0] exp_push_q[$];
    logic [WORD:0] exp_load_q[$];
    logic [WORD:0] exp_stack[$];

    // Stack device model
    logic [WORD:0] mem [DEPTH];
    int            sp;
    logic [WORD:0] rdata_q;
    logic          force_full, force_empty;
    logic [WORD:0] mon_w;

    m_call_ctrl #(.WORD(WORD), .DEPTH(DEPTH), .STK_LAT(STK_LAT)) dut (
        .clk(clk), .reset(reset),
        .call_req(call_req), .ret_req(ret_req), .irq_req(irq_req),
        .pc(pc), .target(target),
        .busy(busy), .ack(ack), .pc_load(pc_load), .pc_next(pc_next),
        .irq_ret(irq_ret), .stk_push(stk_push), .stk_pop(stk_pop),
        .stk_wdata(stk_wdata), .stk_rdata(stk_rdata),
        .stk_full(stk_full), .stk_empty(stk_empty),
        .depth(depth), .fault(fault), .fault_code(fault_code),
        .fault_clr(fault_clr), .dbg_state(dbg_state)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
        $fatal(1, "timeout");
    end

    // Stack model: popped word appears on rdata from the cycle after the pop.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            sp      <= 0;
            rdata_q <= '0;
        end else if (stk_push && sp < DEPTH) begin
            mem[sp] <= stk_wdata;
            sp      <= sp + 1;
            rdata_q <= 17'h15A5A;
        end else if (stk_pop && sp > 0) begin
            rdata_q <= mem[sp-1];
            sp      <= sp - 1;
        end
    end
    assign stk_rdata = rdata_q;
    assign stk_full  = (sp == DEPTH) || force_full;
    assign stk_empty = (sp == 0) || force_empty;

    // Scoreboard monitor: compares every push word and every redirect.
    always @(negedge clk) begin
        if (reset) begin
            if (stk_push) begin
                push_cnt++;
                checks++;
                if (exp_push_q.size() == 0) begin
                    failures++;
                    $display("FAIL push_unexpected: got stk_wdata=%h, required no push", stk_wdata);
                end else begin
                    mon_w = exp_push_q.pop_front();
                    if (stk_wdata !== mon_w) begin
                        failures++;
                        $display("FAIL push_data: got %h, required %h", stk_wdata, mon_w);
                    end
                end
            end
            if (stk_pop) pop_cnt++;
            if (pc_load) begin
                load_cnt++;
                checks++;
                if (exp_load_q.size() == 0) begin
                    failures++;
                    $display("FAIL load_unexpected: got pc_next=%h irq_ret=%b, required no pc_load", pc_next, irq_ret);
                end else begin
                    mon_w = exp_load_q.pop_front();
                    if ({irq_ret, pc_next} !== mon_w) begin
                        failures++;
                        $display("FAIL load_data: got {irq_ret,pc_next}=%h, required %h", {irq_ret, pc_next}, mon_w);
                    end
                end
            end
            if (stk_push && stk_pop) begin
                checks++;
                failures++;
                $display("FAIL push_pop_overlap: got both high, required at most one");
            end
        end
    end

    // Driver: issue one request (called at a negedge), wait for ack, check.
    task automatic do_req(input logic r_irq, input logic r_call, input logic r_ret,
                          input logic [WORD-1:0] p, input logic [WORD-1:0] t,
                          input logic exp_fault, input logic [1:0] exp_code,
                          input string nm);
        int k, p0, q0, exp_lat, exp_push, exp_pop;
        logic got;
        logic [WORD-1:0] rp;
        logic [WORD:0] w;
        p0 = push_cnt;
        q0 = pop_cnt;
        exp_push = 0;
        exp_pop  = 0;
        if (r_irq || r_call) begin
            exp_lat = exp_fault ? 1 : 2;
            if (!exp_fault) begin
                rp = p + 16'd1;
                exp_push_q.push_back({r_irq, rp});
                exp_load_q.push_back({1'b0, t});
                exp_stack.push_back({r_irq, rp});
                exp_depth++;
                exp_push = 1;
            end
        end else begin
            exp_lat = exp_fault ? 1 : 1 + STK_LAT;
            if (!exp_fault && exp_stack.size() > 0) begin
                w = exp_stack.pop_back();
                exp_load_q.push_back(w);
                exp_depth--;
                exp_pop = 1;
            end
        end
        irq_req = r_irq; call_req = r_call; ret_req = r_ret; pc = p; target = t;
        k = 0; got = 1'b0;
        while (!got && k < 20) begin
            @(negedge clk);
            k++;
            if (ack) got = 1'b1;
        end
        irq_req = 1'b0; call_req = 1'b0; ret_req = 1'b0;
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL %s_ack_timeout: got no ack in 20 cycles, required ack at cycle %0d", nm, exp_lat);
        end else if (k != exp_lat) begin
            failures++;
            $display("FAIL %s_latency: got ack at cycle %0d, required %0d", nm, k, exp_lat);
        end
        checks++;
        if (fault !== exp_fault || fault_code !== exp_code) begin
            failures++;
            $display("FAIL %s_fault: got fault=%b code=%b, required fault=%b code=%b", nm, fault, fault_code, exp_fault, exp_code);
        end
        checks++;
        if (depth !== 3'(exp_depth)) begin
            failures++;
            $display("FAIL %s_depth: got %0d, required %0d", nm, depth, exp_depth);
        end
        @(negedge clk);
        checks++;
        if (ack !== 1'b0 || pc_load !== 1'b0 || irq_ret !== 1'b0) begin
            failures++;
            $display("FAIL %s_pulse_drop: got ack=%b pc_load=%b irq_ret=%b, required all 0", nm, ack, pc_load, irq_ret);
        end
        checks++;
        if (push_cnt - p0 != exp_push || pop_cnt - q0 != exp_pop) begin
            failures++;
            $display("FAIL %s_stack_ops: got pushes=%0d pops=%0d, required pushes=%0d pops=%0d", nm, push_cnt - p0, pop_cnt - q0, exp_push, exp_pop);
        end
    endtask

    task automatic clear_fault(input string nm);
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        checks++;
        if (fault !== 1'b0 || fault_code !== 2'b00) begin
            failures++;
            $display("FAIL %s_clear: got fault=%b code=%b, required 0/00", nm, fault, fault_code);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        call_req = 0; ret_req = 0; irq_req = 0; pc = '0; target = '0;
        fault_clr = 0; force_full = 0; force_empty = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, ack, pc_load, irq_ret, stk_push, stk_pop} !== 6'b0) begin
            failures++;
            $display("FAIL reset_strobes: got %b, required 000000", {busy, ack, pc_load, irq_ret, stk_push, stk_pop});
        end
        checks++;
        if (pc_next !== '0 || stk_wdata !== '0) begin
            failures++;
            $display("FAIL reset_data: got pc_next=%h stk_wdata=%h, required 0", pc_next, stk_wdata);
        end
        checks++;
        if (depth !== 3'd0 || fault !== 1'b0 || fault_code !== 2'b00 || dbg_state !== 3'd0) begin
            failures++;
            $display("FAIL reset_state: got depth=%0d fault=%b code=%b state=%0d, required 0", depth, fault, fault_code, dbg_state);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_call_ret();
        do_req(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0200, 1'b0, 2'b00, "call_basic");
        do_req(1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 2'b00, "ret_basic");
    endtask

    task automatic test_irq_ret();
        // irq and call together: interrupt entry wins, flag bit set, PC wraps.
        do_req(1'b1, 1'b1, 1'b0, 16'hFFFF, 16'h0008, 1'b0, 2'b00, "irq_wrap");
        do_req(1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 2'b00, "irq_ret");
    endtask

    task automatic test_overflow();
        int q0, k;
        logic seen_ack, seen_busy, got;
        logic [WORD:0] w;
        for (int i = 0; i < DEPTH; i++)
            do_req(1'b0, 1'b1, 1'b0, 16'h0100 + 16'(i), 16'h0300 + 16'(i), 1'b0, 2'b00, "ovf_fill");
        do_req(1'b0, 1'b1, 1'b0, 16'h0111, 16'h0311, 1'b1, 2'b01, "ovf_fifth");
        // RET held while faulted: ignored.
        q0 = pop_cnt; seen_ack = 1'b0; seen_busy = 1'b0;
        ret_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ack) seen_ack = 1'b1;
            if (busy) seen_busy = 1'b1;
        end
        checks++;
        if (seen_ack || seen_busy || pop_cnt != q0) begin
            failures++;
            $display("FAIL ovf_ret_ignored: got ack=%b busy=%b pops=%0d, required none", seen_ack, seen_busy, pop_cnt - q0);
        end
        w = exp_stack.pop_back();
        exp_load_q.push_back(w);
        exp_depth--;
        clear_fault("ovf");
        k = 0; got = 1'b0;
        while (!got && k < 20) begin
            @(negedge clk);
            k++;
            if (ack) got = 1'b1;
        end
        ret_req = 1'b0;
        checks++;
        if (!got || k != 1 + STK_LAT) begin
            failures++;
            $display("FAIL ovf_ret_after_clear: got ack=%b at cycle %0d, required ack at %0d", got, k, 1 + STK_LAT);
        end
        checks++;
        if (depth !== 3'(exp_depth)) begin
            failures++;
            $display("FAIL ovf_depth: got %0d, required %0d", depth, exp_depth);
        end
        @(negedge clk);
        for (int i = 0; i < DEPTH - 1; i++)
            do_req(1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 2'b00, "ovf_drain");
    endtask

    task automatic test_underflow();
        do_req(1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b1, 2'b10, "udf_empty");
        clear_fault("udf");
        // stk_full disagreeing with depth=0 still faults.
        force_full = 1'b1;
        do_req(1'b0, 1'b1, 1'b0, 16'h0020, 16'h0400, 1'b1, 2'b01, "force_full");
        force_full = 1'b0;
        clear_fault("force_full");
        // stk_empty disagreeing with depth=1 still faults.
        do_req(1'b0, 1'b1, 1'b0, 16'h0030, 16'h0480, 1'b0, 2'b00, "pre_force_empty");
        force_empty = 1'b1;
        do_req(1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b1, 2'b10, "force_empty");
        force_empty = 1'b0;
        clear_fault("force_empty");
        do_req(1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 2'b00, "post_force_empty");
    endtask

    task automatic test_priority();
        int k;
        logic got;
        exp_push_q.push_back({1'b0, 16'h0041});
        exp_load_q.push_back({1'b0, 16'h0500});
        exp_load_q.push_back({1'b0, 16'h0041});
        call_req = 1'b1; ret_req = 1'b1; pc = 16'h0040; target = 16'h0500;
        k = 0; got = 1'b0;
        while (!got && k < 20) begin
            @(negedge clk);
            k++;
            if (ack) got = 1'b1;
        end
        call_req = 1'b0;
        checks++;
        if (!got || k != 2 || pc_next !== 16'h0500) begin
            failures++;
            $display("FAIL prio_call_first: got ack=%b cycle=%0d pc_next=%h, required cycle 2 pc_next=0500", got, k, pc_next);
        end
        k = 0; got = 1'b0;
        while (!got && k < 20) begin
            @(negedge clk);
            k++;
            if (ack) got = 1'b1;
        end
        ret_req = 1'b0;
        checks++;
        if (!got || k != 2 + STK_LAT || pc_next !== 16'h0041 || depth !== 3'd0) begin
            failures++;
            $display("FAIL prio_ret_second: got ack=%b cycle=%0d pc_next=%h depth=%0d, required cycle %0d pc_next=0041 depth 0", got, k, pc_next, depth, 2 + STK_LAT);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [WORD-1:0] rp, rt;
        for (int i = 0; i < 3; i++) begin
            rp = 16'($urandom_range(0, 16'hFFFF));
            rt = 16'($urandom_range(0, 16'hFFFF));
            do_req(1'($urandom_range(0, 1)), 1'b1, 1'b0, rp, rt, 1'b0, 2'b00, "b2b_call");
        end
        for (int i = 0; i < 3; i++)
            do_req(1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 2'b00, "b2b_ret");
    endtask

    task automatic test_reset_mid_push();
        int l0;
        logic seen;
        do_req(1'b0, 1'b1, 1'b0, 16'h0050, 16'h0700, 1'b0, 2'b00, "pre_rst");
        exp_push_q.push_back({1'b0, 16'h0021});
        call_req = 1'b1; pc = 16'h0020; target = 16'h0600;
        @(negedge clk);
        checks++;
        if (stk_push !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_push_pulse: got stk_push=%b, required 1", stk_push);
        end
        #2 reset = 1'b0;
        call_req = 1'b0;
        #1;
        checks++;
        if ({busy, ack, pc_load, stk_push, stk_pop} !== 5'b0 || depth !== 3'd0 || stk_wdata !== '0) begin
            failures++;
            $display("FAIL rst_mid_push_outputs: got strobes=%b depth=%0d wdata=%h, required 0", {busy, ack, pc_load, stk_push, stk_pop}, depth, stk_wdata);
        end
        exp_stack.delete();
        exp_depth = 0;
        @(negedge clk);
        reset = 1'b1;
        l0 = load_cnt; seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ack || pc_load || stk_push) seen = 1'b1;
        end
        checks++;
        if (seen || load_cnt != l0) begin
            failures++;
            $display("FAIL rst_mid_push_no_load: got a late pulse, required none");
        end
    endtask

    initial begin
        test_reset();
        test_call_ret();
        test_irq_ret();
        test_overflow();
        test_underflow();
        test_priority();
        test_back_to_back();
        test_reset_mid_push();
        checks++;
        if (exp_push_q.size() != 0 || exp_load_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pushes and %0d loads outstanding, required 0", exp_push_q.size(), exp_load_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
